// File: rtl/aes_pkg.sv
// Shared types and constants for the AES128 byte-stream front/back end.
package aes_pkg;

  // One AES block is 16 bytes; byte indices need 4 bits.
  localparam int BLOCK_BYTES = 16;
  localparam int IDX_W       = 4;
  localparam int WORD_W      = BLOCK_BYTES * 8;

  // LOAD collects key/data bytes, WAIT covers the core latency,
  // DRAIN streams the ciphertext back out.
  typedef enum logic [1:0] {
    LOAD  = 2'd0,
    WAIT  = 2'd1,
    DRAIN = 2'd2
  } state_t;

  // Big-endian assembly: every new byte enters at the bottom, so after
  // 16 shifts the first byte sits in bits [127:120].
  function automatic logic [WORD_W-1:0] shift_in_byte(
    input logic [WORD_W-1:0] word,
    input logic [7:0]        new_byte
  );
    return {word[WORD_W-9:0], new_byte};
  endfunction

endpackage

// File: rtl/aes_out_serializer.sv
// Captures the 128-bit ciphertext and streams it out MSB byte first.
module aes_out_serializer
  import aes_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              capture,
  input  logic [WORD_W-1:0] capture_data,
  input  logic              m_ready,
  output logic              m_valid,
  output logic [7:0]        m_data,
  output logic              m_last,
  output logic              done
);

  logic [WORD_W-1:0] out_reg;
  logic [IDX_W-1:0]  out_cnt_reg;
  logic              valid_reg;
  logic [7:0]        out_bytes [BLOCK_BYTES];
  logic              handshake;

  // Byte view of the captured block, byte 0 being the most significant.
  for (genvar gi = 0; gi < BLOCK_BYTES; gi++) begin : g_out_bytes
    assign out_bytes[gi] = out_reg[WORD_W-1-8*gi -: 8];
  end

  assign handshake = valid_reg && m_ready;
  assign m_valid   = valid_reg;
  assign m_data    = out_bytes[out_cnt_reg];
  assign m_last    = valid_reg && (out_cnt_reg == IDX_W'(BLOCK_BYTES-1));
  assign done      = handshake && m_last;

  // Capture loads the block and restarts the index; each handshake advances
  // it, and the last byte's handshake drops valid.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      out_reg     <= '0;
      out_cnt_reg <= '0;
      valid_reg   <= 1'b0;
    end else if (capture) begin
      out_reg     <= capture_data;
      out_cnt_reg <= '0;
      valid_reg   <= 1'b1;
    end else if (handshake) begin
      out_cnt_reg <= out_cnt_reg + 1'b1;
      if (out_cnt_reg == IDX_W'(BLOCK_BYTES-1)) begin
        valid_reg <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/aes_byte_stream_if.sv
// Byte-stream wrapper around AES128: assembles key and plaintext from a byte
// stream, waits out the core latency and serializes the ciphertext.
module aes_byte_stream_if
  import aes_pkg::*;
#(
  parameter int CORE_LATENCY = 12,
  parameter int LAT_W        = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic              s_sel,
  input  logic [7:0]        s_data,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [7:0]        m_data,
  output logic              m_last,
  output logic [WORD_W-1:0] core_data,
  output logic [WORD_W-1:0] core_key,
  input  logic [WORD_W-1:0] core_out,
  output logic              busy
);

  state_t            state_reg, state_next;
  logic [WORD_W-1:0] data_reg, data_next;
  logic [WORD_W-1:0] key_reg, key_next;
  logic [IDX_W-1:0]  data_cnt_reg, data_cnt_next;
  logic [IDX_W-1:0]  key_cnt_reg, key_cnt_next;
  logic              data_full_reg, data_full_next;
  logic              key_full_reg, key_full_next;
  logic [LAT_W-1:0]  lat_cnt_reg, lat_cnt_next;
  logic              capture;
  logic              drain_done;
  logic              accept;

  // The core sees the assembly registers directly; nothing loads outside
  // LOAD, so they stay stable for the whole latency window.
  assign core_data = data_reg;
  assign core_key  = key_reg;
  assign busy      = (state_reg != LOAD);

  // State and assembly registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg     <= LOAD;
      data_reg      <= '0;
      key_reg       <= '0;
      data_cnt_reg  <= '0;
      key_cnt_reg   <= '0;
      data_full_reg <= 1'b0;
      key_full_reg  <= 1'b0;
      lat_cnt_reg   <= '0;
    end else begin
      state_reg     <= state_next;
      data_reg      <= data_next;
      key_reg       <= key_next;
      data_cnt_reg  <= data_cnt_next;
      key_cnt_reg   <= key_cnt_next;
      data_full_reg <= data_full_next;
      key_full_reg  <= key_full_next;
      lat_cnt_reg   <= lat_cnt_next;
    end
  end

  // Next-state, byte assembly and handshake decode.
  always_comb begin
    state_next     = state_reg;
    data_next      = data_reg;
    key_next       = key_reg;
    data_cnt_next  = data_cnt_reg;
    key_cnt_next   = key_cnt_reg;
    data_full_next = data_full_reg;
    key_full_next  = key_full_reg;
    lat_cnt_next   = lat_cnt_reg;
    capture        = 1'b0;
    s_ready        = 1'b0;
    accept         = 1'b0;

    case (state_reg)
      LOAD: begin
        // Data bytes stall once the block is full; key bytes stall only
        // when both halves are complete (otherwise they restart the key).
        s_ready = !(!s_sel && data_full_reg) &&
                  !(s_sel && key_full_reg && data_full_reg);
        accept  = s_valid && s_ready;
        if (accept) begin
          if (s_sel) begin
            key_next     = shift_in_byte(key_reg, s_data);
            key_cnt_next = key_cnt_reg + 1'b1;
            if (key_full_reg) begin
              // A full key being overwritten: this byte is byte 0 of a new key.
              key_full_next = 1'b0;
            end else if (key_cnt_reg == IDX_W'(BLOCK_BYTES-1)) begin
              key_full_next = 1'b1;
            end
          end else begin
            data_next     = shift_in_byte(data_reg, s_data);
            data_cnt_next = data_cnt_reg + 1'b1;
            if (data_cnt_reg == IDX_W'(BLOCK_BYTES-1)) begin
              data_full_next = 1'b1;
            end
          end
        end
        if (data_full_reg && key_full_reg) begin
          state_next   = WAIT;
          lat_cnt_next = '0;
        end
      end

      WAIT: begin
        lat_cnt_next = lat_cnt_reg + 1'b1;
        if (lat_cnt_reg == LAT_W'(CORE_LATENCY-1)) begin
          capture    = 1'b1;
          state_next = DRAIN;
        end
      end

      DRAIN: begin
        // The key stays resident; only the data half must be reloaded.
        if (drain_done) begin
          state_next     = LOAD;
          data_full_next = 1'b0;
        end
      end

      default: begin
        state_next = LOAD;
      end
    endcase
  end

  aes_out_serializer u_out_serializer (
    .clk          (clk),
    .reset        (reset),
    .capture      (capture),
    .capture_data (core_out),
    .m_ready      (m_ready),
    .m_valid      (m_valid),
    .m_data       (m_data),
    .m_last       (m_last),
    .done         (drain_done)
  );

endmodule

// File: tb/tb_aes_byte_stream_if.sv
// Testbench for aes_byte_stream_if with a behavioural AES-128 core model.
module tb_aes_byte_stream_if;

  localparam int CORE_LATENCY = 12;
  localparam int LAT_W        = 5;

  logic         clk = 1'b0;
  logic         reset;
  logic         s_valid;
  logic         s_ready;
  logic         s_sel;
  logic [7:0]   s_data;
  logic         m_valid;
  logic         m_ready;
  logic [7:0]   m_data;
  logic         m_last;
  logic [127:0] core_data;
  logic [127:0] core_key;
  logic [127:0] core_out;
  logic         busy;

  int checks = 0;
  int errors = 0;

  logic [8:0]   exp_q [$];
  logic [7:0]   sbox [256];
  logic [127:0] core_pipe [CORE_LATENCY];

  always #5 clk = ~clk;

  aes_byte_stream_if #(
    .CORE_LATENCY (CORE_LATENCY),
    .LAT_W        (LAT_W)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .s_valid   (s_valid),
    .s_ready   (s_ready),
    .s_sel     (s_sel),
    .s_data    (s_data),
    .m_valid   (m_valid),
    .m_ready   (m_ready),
    .m_data    (m_data),
    .m_last    (m_last),
    .core_data (core_data),
    .core_key  (core_key),
    .core_out  (core_out),
    .busy      (busy)
  );

  // ---------------- AES-128 reference model ----------------
  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xt(x);
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
    return (b << n) | (b >> (8 - n));
  endfunction

  task automatic build_sbox();
    logic [7:0] inv;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++) begin
        if (gmul(x[7:0], y[7:0]) == 8'h01) inv = y[7:0];
      end
      sbox[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^
                rotl8(inv, 4) ^ 8'h63;
    end
  endtask

  function automatic logic [127:0] sub_bytes(input logic [127:0] s);
    logic [127:0] r;
    r = '0;
    for (int i = 0; i < 16; i++) r[127-8*i -: 8] = sbox[s[127-8*i -: 8]];
    return r;
  endfunction

  function automatic logic [127:0] shift_rows(input logic [127:0] s);
    logic [127:0] r;
    r = '0;
    for (int c = 0; c < 4; c++)
      for (int rr = 0; rr < 4; rr++)
        r[127-8*(4*c+rr) -: 8] = s[127-8*(4*((c+rr)%4)+rr) -: 8];
    return r;
  endfunction

  function automatic logic [127:0] mix_columns(input logic [127:0] s);
    logic [127:0] r;
    logic [7:0] a0, a1, a2, a3;
    r = '0;
    for (int c = 0; c < 4; c++) begin
      a0 = s[127-32*c -: 8];
      a1 = s[119-32*c -: 8];
      a2 = s[111-32*c -: 8];
      a3 = s[103-32*c -: 8];
      r[127-32*c -: 8] = xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3;
      r[119-32*c -: 8] = a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3;
      r[111-32*c -: 8] = a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3;
      r[103-32*c -: 8] = xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3);
    end
    return r;
  endfunction

  function automatic logic [127:0] next_rk(input logic [127:0] rk, input logic [7:0] rcon);
    logic [31:0] w3, t, n0, n1, n2, n3;
    w3 = rk[31:0];
    t  = {sbox[w3[23:16]], sbox[w3[15:8]], sbox[w3[7:0]], sbox[w3[31:24]]} ^ {rcon, 24'h0};
    n0 = rk[127:96] ^ t;
    n1 = rk[95:64] ^ n0;
    n2 = rk[63:32] ^ n1;
    n3 = rk[31:0] ^ n2;
    return {n0, n1, n2, n3};
  endfunction

  function automatic logic [127:0] aes_encrypt(input logic [127:0] key, input logic [127:0] pt);
    logic [127:0] rk, st;
    logic [7:0]   rcon;
    rk   = key;
    st   = pt ^ rk;
    rcon = 8'h01;
    for (int round = 1; round <= 10; round++) begin
      st = shift_rows(sub_bytes(st));
      if (round != 10) st = mix_columns(st);
      rk   = next_rk(rk, rcon);
      rcon = xt(rcon);
      st   = st ^ rk;
    end
    return st;
  endfunction

  // Core model: output is valid CORE_LATENCY cycles after its inputs settle.
  always @(posedge clk) begin
    core_pipe[0] <= aes_encrypt(core_key, core_data);
    for (int i = 1; i < CORE_LATENCY; i++) core_pipe[i] <= core_pipe[i-1];
  end
  assign core_out = core_pipe[CORE_LATENCY-1];

  // ---------------- stimulus helpers ----------------
  task automatic push_block(input logic [127:0] ct);
    for (int i = 0; i < 16; i++) exp_q.push_back({(i == 15), ct[127-8*i -: 8]});
  endtask

  task automatic send_byte(input logic sel, input logic [7:0] b);
    int n;
    bit acc;
    n = 0;
    acc = 1'b0;
    s_valid = 1'b1;
    s_sel   = sel;
    s_data  = b;
    while (!acc && n < 64) begin
      #4;
      acc = s_ready;
      @(posedge clk);
      #1;
      n++;
    end
    s_valid = 1'b0;
    checks++;
    if (!acc) begin
      errors++;
      $display("FAIL send_byte: byte sel=%0d data=%02h not accepted within 64 cycles", sel, b);
    end
  endtask

  task automatic send_word(input logic sel, input logic [127:0] w);
    for (int i = 0; i < 16; i++) send_byte(sel, w[127-8*i -: 8]);
  endtask

  task automatic do_reset();
    reset = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b1;
  endtask

  task automatic wait_valid_latency(input int expected);
    int n;
    n = 0;
    while (!m_valid && n < 200) begin
      @(posedge clk);
      #1;
      n++;
    end
    checks++;
    if (n != expected) begin
      errors++;
      $display("FAIL latency: m_valid after %0d cycles, expected %0d", n, expected);
    end
  endtask

  // Drains one block against the scoreboard while presenting a data byte
  // upstream, which must be refused until the block is out.
  task automatic drain_block(input bit random_ready);
    int got, n;
    bit prev_stall;
    logic [7:0] prev_data;
    logic [8:0] e;
    got = 0;
    n = 0;
    prev_stall = 1'b0;
    prev_data = 8'h00;
    s_valid = 1'b1;
    s_sel   = 1'b0;
    s_data  = 8'ha5;
    while (got < 16 && n < 1000) begin
      m_ready = random_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      #4;
      checks++;
      if (s_ready !== 1'b0) begin
        errors++;
        $display("FAIL drain_s_ready: s_ready=%b while busy, expected 0", s_ready);
      end
      if (m_valid) begin
        if (prev_stall) begin
          checks++;
          if (m_data !== prev_data) begin
            errors++;
            $display("FAIL stall_hold: m_data=%02h changed while stalled, expected %02h", m_data, prev_data);
          end
        end
        if (m_ready) begin
          checks++;
          if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_byte: m_data=%02h with empty scoreboard", m_data);
          end else begin
            e = exp_q.pop_front();
            if ({m_last, m_data} !== e) begin
              errors++;
              $display("FAIL out_byte %0d: got last=%b data=%02h, expected last=%b data=%02h",
                       got, m_last, m_data, e[8], e[7:0]);
            end
          end
          got++;
        end
        prev_stall = !m_ready;
        prev_data  = m_data;
      end else begin
        if (got > 0) begin
          checks++;
          errors++;
          $display("FAIL valid_drop: m_valid=0 after %0d of 16 bytes, expected 1", got);
        end
        prev_stall = 1'b0;
      end
      @(posedge clk);
      #1;
      n++;
    end
    checks++;
    if (got < 16) begin
      errors++;
      $display("FAIL drain_timeout: only %0d of 16 bytes seen", got);
    end
    // One cycle after the m_last handshake: back in LOAD, upstream open.
    checks++;
    if (s_ready !== 1'b1 || m_valid !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL post_drain: s_ready=%b m_valid=%b busy=%b, expected 1 0 0", s_ready, m_valid, busy);
    end
    s_valid = 1'b0;
    m_ready = 1'b1;
  endtask

  task automatic check_idle_outputs(input string tag);
    checks++;
    if (s_ready !== 1'b1 || m_valid !== 1'b0 || m_last !== 1'b0 || m_data !== 8'h00 ||
        busy !== 1'b0 || core_data !== 128'h0 || core_key !== 128'h0) begin
      errors++;
      $display("FAIL %s: s_ready=%b m_valid=%b m_last=%b m_data=%02h busy=%b core_data=%032h core_key=%032h, expected 1 0 0 00 0 0 0",
               tag, s_ready, m_valid, m_last, m_data, busy, core_data, core_key);
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    #1;
    check_idle_outputs("reset_state");
    @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk);
    #1;
    check_idle_outputs("after_reset_release");
  endtask

  task automatic test_fips_vector();
    send_word(1'b1, 128'h000102030405060708090a0b0c0d0e0f);
    send_word(1'b0, 128'h00112233445566778899aabbccddeeff);
    push_block(128'h69c4e0d86a7b0430d8cdb78070b4c55a);
    checks++;
    if (core_key !== 128'h000102030405060708090a0b0c0d0e0f ||
        core_data !== 128'h00112233445566778899aabbccddeeff) begin
      errors++;
      $display("FAIL fips_assembly: core_key=%032h core_data=%032h", core_key, core_data);
    end
    wait_valid_latency(CORE_LATENCY + 1);
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL busy_drain: busy=%b, expected 1", busy);
    end
    drain_block(1'b0);
  endtask

  task automatic test_interleave();
    logic [127:0] k, d;
    k = 128'h000102030405060708090a0b0c0d0e0f;
    d = 128'h00112233445566778899aabbccddeeff;
    do_reset();
    for (int i = 0; i < 16; i++) begin
      send_byte(1'b0, d[127-8*i -: 8]);
      if (i == 15) begin
        // Data block full: a further data byte must be refused.
        s_valid = 1'b1;
        s_sel   = 1'b0;
        s_data  = 8'hee;
        #4;
        checks++;
        if (s_ready !== 1'b0) begin
          errors++;
          $display("FAIL data_full_ready: s_ready=%b for data byte while full, expected 0", s_ready);
        end
        @(posedge clk);
        #1;
        s_valid = 1'b0;
      end
      send_byte(1'b1, k[127-8*i -: 8]);
    end
    push_block(128'h69c4e0d86a7b0430d8cdb78070b4c55a);
    checks++;
    if (core_data !== d) begin
      errors++;
      $display("FAIL interleave_data: core_data=%032h, expected %032h", core_data, d);
    end
    drain_block(1'b0);
  endtask

  task automatic test_resident_key();
    logic [127:0] k, d1;
    k  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    d1 = {$urandom, $urandom, $urandom, $urandom};
    send_word(1'b1, k);
    send_word(1'b0, d1);
    push_block(aes_encrypt(k, d1));
    drain_block(1'b0);
    send_word(1'b0, 128'h3243f6a8885a308d313198a2e0370734);
    push_block(128'h3925841d02dc09fbdc118597196a0b32);
    checks++;
    if (core_key !== k) begin
      errors++;
      $display("FAIL resident_key: core_key=%032h, expected %032h", core_key, k);
    end
    drain_block(1'b0);
  endtask

  task automatic test_stall();
    logic [127:0] d;
    d = {$urandom, $urandom, $urandom, $urandom};
    send_word(1'b0, d);
    push_block(aes_encrypt(128'h2b7e151628aed2a6abf7158809cf4f3c, d));
    drain_block(1'b1);
  endtask

  task automatic test_reset_wait();
    logic [127:0] k, d;
    send_word(1'b0, {$urandom, $urandom, $urandom, $urandom});
    for (int i = 0; i < 4; i++) begin
      @(posedge clk);
      #1;
    end
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL wait_busy: busy=%b before reset, expected 1", busy);
    end
    reset = 1'b0;
    #1;
    check_idle_outputs("reset_in_wait");
    @(posedge clk);
    #1;
    reset = 1'b1;
    for (int i = 0; i < CORE_LATENCY + 5; i++) begin
      @(posedge clk);
      #1;
      checks++;
      if (m_valid !== 1'b0 || busy !== 1'b0) begin
        errors++;
        $display("FAIL discarded_block: m_valid=%b busy=%b after reset, expected 0 0", m_valid, busy);
      end
    end
    k = {$urandom, $urandom, $urandom, $urandom};
    d = {$urandom, $urandom, $urandom, $urandom};
    send_word(1'b1, k);
    send_word(1'b0, d);
    push_block(aes_encrypt(k, d));
    drain_block(1'b0);
  endtask

  task automatic test_key_restart();
    logic [7:0]   kb [32];
    logic [127:0] k_mid, k_final, d;
    for (int i = 0; i < 32; i++) kb[i] = 8'($urandom);
    k_mid = '0;
    k_final = '0;
    for (int i = 4; i < 20; i++) k_mid = {k_mid[119:0], kb[i]};
    for (int i = 16; i < 32; i++) k_final = {k_final[119:0], kb[i]};
    for (int i = 0; i < 20; i++) send_byte(1'b1, kb[i]);
    checks++;
    if (core_key !== k_mid) begin
      errors++;
      $display("FAIL key_after_20: core_key=%032h, expected %032h", core_key, k_mid);
    end
    // Byte 16 started a new key, so a data block alone must not launch.
    d = {$urandom, $urandom, $urandom, $urandom};
    send_word(1'b0, d);
    for (int i = 0; i < CORE_LATENCY + 5; i++) begin
      @(posedge clk);
      #1;
    end
    checks++;
    if (busy !== 1'b0 || m_valid !== 1'b0) begin
      errors++;
      $display("FAIL partial_key_launch: busy=%b m_valid=%b with incomplete key, expected 0 0", busy, m_valid);
    end
    for (int i = 20; i < 32; i++) send_byte(1'b1, kb[i]);
    push_block(aes_encrypt(k_final, d));
    checks++;
    if (core_key !== k_final) begin
      errors++;
      $display("FAIL key_final: core_key=%032h, expected %032h", core_key, k_final);
    end
    drain_block(1'b0);
  endtask

  initial begin
    reset   = 1'b0;
    s_valid = 1'b0;
    s_sel   = 1'b0;
    s_data  = 8'h00;
    m_ready = 1'b1;
    build_sbox();
    test_reset();
    test_fips_vector();
    test_interleave();
    test_resident_key();
    test_stall();
    test_reset_wait();
    test_key_restart();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_leftover: %0d expected bytes never produced", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
